// File: rtl/foo_arb_pkg.sv
// Shared types and constants for the foo pipe arbiter slice.
package foo_arb_pkg;

    localparam int FOO_DATA_W  = 32;
    localparam int FOO_LATENCY = 2;

    typedef struct packed {
        logic       vld;
        logic [3:0] id;
    } foo_tag_t;

    function automatic logic [2*FOO_DATA_W-1:0] pack_s(
        input logic [FOO_DATA_W-1:0] a,
        input logic [FOO_DATA_W-1:0] b
    );
        return {a, b};
    endfunction

endpackage

// File: rtl/foo_pipe_arbiter_if.sv
// Requester, foo pipe and response signals of the foo pipe arbiter.
interface foo_pipe_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = foo_arb_pkg::FOO_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic [2*DATA_W-1:0]       pipe_s;
    logic [DATA_W-1:0]         pipe_out;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;

    modport master (
        output req_valid, req_a, req_b, pipe_out,
        input  req_ready, pipe_s, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, pipe_out,
        output req_ready, pipe_s, resp_valid, resp_data
    );

endinterface

// File: rtl/foo_rr_arbiter.sv
// Combinational round-robin pick: lowest index at or above rr_ptr (wrapping) wins.
// Latency 0; no backpressure, grant is a pure function of req and rr_ptr.
module foo_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/foo_pipe_arbiter.sv
// Round-robin share of one foo adder pipe among NUM_REQ requesters; optional FOO_ARB_PERF_EN grant counters.
// Latency: grant same cycle, resp_valid pulse LATENCY cycles after grant; 1 op/cycle sustained.
// Backpressure: req_ready is the one-hot grant; responses are never stalled.
module foo_pipe_arbiter
    import foo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FOO_DATA_W,
    parameter int LATENCY = FOO_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    foo_pipe_arbiter_if.slave        bus
`ifdef FOO_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]    perf_grants
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_gated;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   rr_ptr;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;
    foo_tag_t           tag_q [LATENCY];
    foo_tag_t           tag_out;
    logic [NUM_REQ-1:0] resp_vec;

    // Requests seen while in reset must never be accepted.
    assign req_gated = rst ? '0 : bus.req_valid;

    foo_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_gated),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.req_ready = grant;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = bus.req_a[i*DATA_W +: DATA_W];
                b_sel = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        if (DATA_W == FOO_DATA_W) begin : g_pack
            assign bus.pipe_s = pack_s(a_sel, b_sel);
        end else begin : g_cat
            assign bus.pipe_s = {a_sel, b_sel};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Requester IDs travel beside the foo pipe so results can be steered back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{vld: grant_any, id: 4'(grant_idx)};
            for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    always_comb begin
        resp_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_vec[i] = tag_out.vld && (tag_out.id == 4'(i));
        end
    end

    assign bus.resp_valid = resp_vec;
    assign bus.resp_data  = bus.pipe_out;

`ifdef FOO_ARB_PERF_EN
    logic [15:0] perf_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && perf_cnt[i] != 16'hFFFF) perf_cnt[i] <= perf_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_grants[g*16 +: 16] = perf_cnt[g];
    end
`endif

endmodule

// File: tb/tb_foo_pipe_arbiter.sv
// Bench for foo_pipe_arbiter: vector table, corner sequences and random traffic against a schedule model.
module tb_foo_pipe_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] vld;
    logic [W-1:0] a_in [N];
    logic [W-1:0] b_in [N];

    foo_pipe_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    assign bus.req_valid = vld;
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign bus.req_a[g*W +: W] = a_in[g];
        assign bus.req_b[g*W +: W] = b_in[g];
    end

    // Two-stage foo adder stand-in
    logic [W-1:0] p1, p2;
    always @(posedge clk) begin
        p1 <= bus.pipe_s[2*W-1:W] + bus.pipe_s[W-1:0];
        p2 <= p1;
    end
    assign bus.pipe_out = p2;

`ifdef FOO_ARB_PERF_EN
    logic [N*16-1:0] perf_grants;
`endif

    foo_pipe_arbiter #(.NUM_REQ(N), .DATA_W(W), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave)
`ifdef FOO_ARB_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: rotating pointer plus a table of responses keyed by due cycle.
    int           m_ptr = 0;
    int           m_g   = -1;
    logic [N-1:0] exp_rv [8];
    logic [W-1:0] exp_rd [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic sample();
        logic [N-1:0]   er;
        logic [2*W-1:0] es;
        @(negedge clk);
        m_g = rst ? -1 : pick(vld, m_ptr);
        er = '0;
        es = '0;
        if (m_g >= 0) begin
            er[m_g] = 1'b1;
            es = {a_in[m_g], b_in[m_g]};
        end
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("pipe_s", 64'(bus.pipe_s), 64'(es));
        chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv[cyc % 8]));
        if (exp_rv[cyc % 8] != '0) chk("resp_data", 64'(bus.resp_data), 64'(exp_rd[cyc % 8]));
    endtask

    task automatic advance();
        logic [N-1:0] oh;
        @(posedge clk);
        exp_rv[cyc % 8] = '0;
        if (rst) begin
            m_ptr = 0;
            for (int k = 0; k < 8; k++) exp_rv[k] = '0;
        end else if (m_g >= 0) begin
            oh = '0;
            oh[m_g] = 1'b1;
            exp_rv[(cyc + LAT) % 8] = oh;
            exp_rd[(cyc + LAT) % 8] = a_in[m_g] + b_in[m_g];
            m_ptr = (m_g + 1) % N;
        end
        cyc++;
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        vld = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            a_in[i] = a;
            b_in[i] = b;
        end
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] ready;
        logic [N-1:0] resp;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl [11];

    initial begin
        for (int k = 0; k < 8; k++) begin
            exp_rv[k] = '0;
            exp_rd[k] = '0;
        end
        rst = 1'b1;
        vld = '0;
        set_ops('0, '0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with requests present during reset
        vld = 4'hF;
        sample();
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_resp", 64'(bus.resp_valid), 64'h0);
        advance();
        rst = 1'b0;
        vld = '0;

        // Vector table, applied straight after reset (pointer at 0)
        tbl[0]  = '{4'b0100, 32'd5,          32'd7,          4'b0100, 4'b0000, 32'd0};
        tbl[1]  = '{4'b0000, 32'd0,          32'd0,          4'b0000, 4'b0000, 32'd0};
        tbl[2]  = '{4'b0000, 32'd0,          32'd0,          4'b0000, 4'b0100, 32'd12};
        tbl[3]  = '{4'b1111, 32'hFFFF_FFFF,  32'd2,          4'b1000, 4'b0000, 32'd0};
        tbl[4]  = '{4'b1111, 32'h8000_0000,  32'h8000_0000,  4'b0001, 4'b0000, 32'd0};
        tbl[5]  = '{4'b1010, 32'd1,          32'd1,          4'b0010, 4'b1000, 32'd1};
        tbl[6]  = '{4'b1001, 32'd10,         32'd20,         4'b1000, 4'b0001, 32'd0};
        tbl[7]  = '{4'b0110, 32'd3,          32'd4,          4'b0010, 4'b0010, 32'd2};
        tbl[8]  = '{4'b0000, 32'd0,          32'd0,          4'b0000, 4'b1000, 32'd30};
        tbl[9]  = '{4'b0000, 32'd0,          32'd0,          4'b0000, 4'b0010, 32'd7};
        tbl[10] = '{4'b0000, 32'd0,          32'd0,          4'b0000, 4'b0000, 32'd0};
        for (int r = 0; r < 11; r++) begin
            vld = tbl[r].vld;
            set_ops(tbl[r].a, tbl[r].b);
            sample();
            chk($sformatf("tbl%0d_ready", r), 64'(bus.req_ready), 64'(tbl[r].ready));
            chk($sformatf("tbl%0d_resp", r), 64'(bus.resp_valid), 64'(tbl[r].resp));
            if (tbl[r].resp != '0) chk($sformatf("tbl%0d_data", r), 64'(bus.resp_data), 64'(tbl[r].data));
            advance();
        end

        // Full contention rotates 0,1,2,3,0,1,2,3
        reset_dut();
        vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            set_ops(32'(k * 100), 32'(k));
            sample();
            chk("contend_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            advance();
        end
        vld = '0;
        repeat (3) tick();

        // Reset while an op is in flight
        reset_dut();
        set_ops(32'd9, 32'd9);
        vld = 4'b0001;
        sample();
        chk("flight_ready", 64'(bus.req_ready), 64'h1);
        advance();
        rst = 1'b1;
        vld = 4'hF;
        sample();
        chk("rst_gate", 64'(bus.req_ready), 64'h0);
        advance();
        rst = 1'b0;
        vld = '0;
        sample();
        chk("flush_resp", 64'(bus.resp_valid), 64'h0);
        advance();
        vld = 4'b1010;
        sample();
        chk("post_rst_ready", 64'(bus.req_ready), 64'(4'b0010));
        advance();
        vld = '0;
        repeat (3) tick();

        // Requester 3 alone every other cycle
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            vld = 4'b1000;
            set_ops(32'(k), 32'd1);
            sample();
            chk("sparse_ready", 64'(bus.req_ready), 64'(4'b1000));
            advance();
            vld = '0;
            tick();
        end
        vld = 4'hF;
        sample();
        chk("sparse_ptr", 64'(bus.req_ready), 64'h1);
        advance();
        vld = '0;
        repeat (3) tick();

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                a_in[i] = $urandom;
                b_in[i] = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        vld = '0;
        repeat (3) tick();

`ifdef FOO_ARB_PERF_EN
        reset_dut();
        vld = 4'b0010;
        repeat (3) tick();
        vld = '0;
        tick();
        chk("perf_small", 64'(perf_grants), 64'h0000_0000_0003_0000);
        vld = 4'b0010;
        repeat (70000) tick();
        vld = '0;
        tick();
        chk("perf_sat", 64'(perf_grants), 64'h0000_0000_FFFF_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
